clock_with_mode_fsm: RTL and testbench
======================================

CLOCK_WITH_MODE_FSM -- requirements
Module: clock_with_mode_fsm

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and reset.
REQ-002 Ports SHALL be:
- clk  in  1  system clock; one cycle = one second of time
- reset  in  1  synchronous active-high reset
- mode_btn  in  1  mode-cycle button
- add_hour  in  1  hour (or timer-second) increment button
- add_minute  in  1  minute increment button
- set_timer_btn  in  1  confirm and start the timer
- set_alarm_btn  in  1  confirm and arm the alarm
- AM_mode  in  1  1 = 12-hour display, 0 = 24-hour display
- sec, min, hr  out  6 each  displayed time
- AM_PM  out  1  1 = PM
- day  out  5;  month  out  4;  year  out  12  date
- timer_buzzer, alarm_buzzer  out  1 each  buzzers
- timer_min_left, timer_sec_left  out  6 each  timer value

Function
REQ-003 Each button SHALL be rising-edge detected against its own previous-cycle register; a held button counts once.
REQ-004 The internal state register `state` SHALL take values CLOCK=0, SET_TIMER=1, SET_ALARM=2.
REQ-005 A mode_btn edge SHALL step the state 0->1->2->0.
REQ-006 A set_timer_btn edge in SET_TIMER SHALL start the timer and go to CLOCK; it SHALL be ignored in other states.
REQ-007 A set_alarm_btn edge in SET_ALARM SHALL set alarm_en=1 and go to CLOCK; it SHALL be ignored in other states.
REQ-008 Time SHALL be kept as hr24 (0-23), min, sec.
REQ-009 Time SHALL advance by one second every cycle in every state: sec 59->0 carries min; min 59->0 carries hr24; hr24 23->0 carries the date.
REQ-010 Date advance SHALL follow month lengths 31/28-29/31/30/31/30/31/31/30/31/30/31.
REQ-011 Leap year SHALL be (year%4==0 and year%100!=0) or year%400==0.
REQ-012 Day past month end SHALL go to 1 with month+1; month 12->1 SHALL increment year; year 4095->0.
REQ-013 In CLOCK, an add_hour edge SHALL set hr24=(hr24+1)%24 and an add_minute edge SHALL set min=(min+1)%60, with no carry.
REQ-014 Any cycle containing a CLOCK-state time adjustment SHALL not advance sec.
REQ-015 In SET_ALARM, add_hour SHALL set alarm_hr=(alarm_hr+1)%24 and add_minute SHALL set alarm_min=(alarm_min+1)%60; time keeps running.
REQ-016 alarm_buzzer SHALL be combinational: alarm_en && hr24==alarm_hr && min==alarm_min, giving a high level for the whole matching minute; it stays armed afterwards.
REQ-017 In SET_TIMER, add_minute SHALL set t_min=(t_min+1)%60 and add_hour SHALL set t_sec=(t_sec+1)%60; starting the timer clears timer_buzzer.
REQ-018 Starting with t_min:t_sec = 00:00 SHALL not run the timer.
REQ-019 While the timer runs, t_sec:t_min SHALL decrement once per cycle with borrow (00 sec -> 59, min-1).
REQ-020 The cycle the timer reaches 00:00, running SHALL clear and timer_buzzer SHALL set.
REQ-021 timer_buzzer SHALL stay high until a mode_btn edge, a timer start, or reset.
REQ-022 timer_min_left/timer_sec_left SHALL equal t_min/t_sec at all times.
REQ-023 Display with AM_mode=1: hr = 12 if hr24 is 0 or 12, hr24-12 if hr24>12, otherwise hr24; AM_PM=(hr24>=12).
REQ-024 Display with AM_mode=0: hr=hr24 and AM_PM=0; sec and min are always the raw counters.
REQ-025 Display outputs SHALL be combinational from the registers and AM_mode.

Reset
REQ-026 On a clk edge with reset=1, the block SHALL set state=CLOCK, hr24:min:sec=00:00:00, date=01/01/2000, alarm 00:00 with alarm_en=0, t_min:t_sec=00:00, timer idle, timer_buzzer=0, and all edge registers to 0.
REQ-027 Reset SHALL override all other activity, including mid-countdown.
REQ-028 Right after reset with AM_mode=1, the outputs SHALL be hr=12, AM_PM=0, alarm_buzzer=0.

Verification
REQ-029 Alarm: release reset, two mode_btn pulses (state=2), add_hour, add_minute, set_alarm_btn -> state=0; alarm_buzzer rises when time becomes 01:01:00 and falls at 01:02:00.
REQ-030 Rollover: set time 23:59:59 on 28/02/2023 -> next cycle 00:00:00 01/03/2023; on 28/02/2024 -> 29/02/2024.
REQ-031 Display: hr24=13 -> hr=1, AM_PM=1 with AM_mode=1; hr=13, AM_PM=0 with AM_mode=0; hr24=0 -> hr=12, AM_PM=0.
REQ-032 Timer: mode_btn once, add_minute once, add_hour x3, set_timer_btn -> 01:03 counts down to 00:00 in 63 cycles, timer_buzzer high until next mode_btn edge.
REQ-033 Held button: add_minute held 5 cycles in SET_ALARM -> alarm_min increases by 1 only.
REQ-034 Reset mid-countdown -> timer 00:00, timer_buzzer=0, state=0.

Source files
------------

// File: rtl/clock_with_mode_fsm.sv
// clock_with_mode_fsm: one-second-per-cycle clock/calendar with alarm, countdown timer and 12/24h display
module clock_with_mode_fsm (
    input  logic        clk,
    input  logic        reset,
    input  logic        mode_btn,
    input  logic        add_hour,
    input  logic        add_minute,
    input  logic        set_timer_btn,
    input  logic        set_alarm_btn,
    input  logic        AM_mode,
    output logic [5:0]  sec,
    output logic [5:0]  min,
    output logic [5:0]  hr,
    output logic        AM_PM,
    output logic [4:0]  day,
    output logic [3:0]  month,
    output logic [11:0] year,
    output logic        timer_buzzer,
    output logic        alarm_buzzer,
    output logic [5:0]  timer_min_left,
    output logic [5:0]  timer_sec_left
);
    typedef enum logic [1:0] {CLOCK = 2'd0, SET_TIMER = 2'd1, SET_ALARM = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [4:0]  btn_q, btn_d, btn_e;
    logic [4:0]  hr24_q, hr24_d, alarm_hr_q, alarm_hr_d, day_q, day_d;
    logic [5:0]  min_q, min_d, sec_q, sec_d, alarm_min_q, alarm_min_d;
    logic [5:0]  t_min_q, t_min_d, t_sec_q, t_sec_d;
    logic [3:0]  month_q, month_d;
    logic [11:0] year_q, year_d;
    logic        alarm_en_q, alarm_en_d, running_q, running_d, buzz_q, buzz_d;
    logic        mode_e, hour_e, minute_e, timer_e, alarm_e, start, arm, adj;
    logic        leap;
    logic [4:0]  mdays, h12;

    // Rising-edge detection; each button compared against its own previous sample
    always_comb begin
        btn_d = {mode_btn, add_hour, add_minute, set_timer_btn, set_alarm_btn};
        btn_e = btn_d & ~btn_q;
        {mode_e, hour_e, minute_e, timer_e, alarm_e} = btn_e;
        start = timer_e && state_q == SET_TIMER && !mode_e;
        arm   = alarm_e && state_q == SET_ALARM && !mode_e;
        adj   = state_q == CLOCK && (hour_e || minute_e);
    end

    // Month length for the current month/year
    always_comb begin
        leap  = ((year_q % 12'd4) == 12'd0 && (year_q % 12'd100) != 12'd0) || (year_q % 12'd400) == 12'd0;
        mdays = (month_q == 4'd2) ? (leap ? 5'd29 : 5'd28) :
                (month_q == 4'd4 || month_q == 4'd6 || month_q == 4'd9 || month_q == 4'd11) ? 5'd30 : 5'd31;
    end

    // Mode FSM next state; mode button takes priority over confirm buttons
    always_comb begin
        state_d = state_q;
        if (mode_e)
            state_d = (state_q == CLOCK) ? SET_TIMER : (state_q == SET_TIMER) ? SET_ALARM : CLOCK;
        else if (start || arm)
            state_d = CLOCK;
    end

    // Timekeeping: manual adjust in CLOCK freezes seconds, otherwise tick with full carry chain
    always_comb begin
        hr24_d  = hr24_q;
        min_d   = min_q;
        sec_d   = sec_q;
        day_d   = day_q;
        month_d = month_q;
        year_d  = year_q;
        if (adj) begin
            if (hour_e)   hr24_d = (hr24_q == 5'd23) ? 5'd0 : hr24_q + 5'd1;
            if (minute_e) min_d  = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
        end else begin
            sec_d = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
            if (sec_q == 6'd59) begin
                min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                if (min_q == 6'd59) begin
                    hr24_d = (hr24_q == 5'd23) ? 5'd0 : hr24_q + 5'd1;
                    if (hr24_q == 5'd23) begin
                        day_d = (day_q >= mdays) ? 5'd1 : day_q + 5'd1;
                        if (day_q >= mdays) begin
                            month_d = (month_q == 4'd12) ? 4'd1 : month_q + 4'd1;
                            if (month_q == 4'd12) year_d = year_q + 12'd1;
                        end
                    end
                end
            end
        end
    end

    // Alarm setting and arming
    always_comb begin
        alarm_hr_d  = alarm_hr_q;
        alarm_min_d = alarm_min_q;
        alarm_en_d  = alarm_en_q || arm;
        if (state_q == SET_ALARM && hour_e)   alarm_hr_d  = (alarm_hr_q == 5'd23) ? 5'd0 : alarm_hr_q + 5'd1;
        if (state_q == SET_ALARM && minute_e) alarm_min_d = (alarm_min_q == 6'd59) ? 6'd0 : alarm_min_q + 6'd1;
    end

    // Countdown timer: edit in SET_TIMER, decrement with borrow while running, buzz on reaching 00:00
    always_comb begin
        t_min_d   = t_min_q;
        t_sec_d   = t_sec_q;
        running_d = running_q;
        buzz_d    = buzz_q;
        if (state_q == SET_TIMER && minute_e) t_min_d = (t_min_q == 6'd59) ? 6'd0 : t_min_q + 6'd1;
        if (state_q == SET_TIMER && hour_e)   t_sec_d = (t_sec_q == 6'd59) ? 6'd0 : t_sec_q + 6'd1;
        if (running_q) begin
            t_sec_d = (t_sec_q == 6'd0) ? 6'd59 : t_sec_q - 6'd1;
            t_min_d = (t_sec_q == 6'd0) ? t_min_q - 6'd1 : t_min_q;
            if (t_min_q == 6'd0 && t_sec_q == 6'd1) begin
                running_d = 1'b0;
                buzz_d    = 1'b1;
            end
        end
        if (mode_e) buzz_d = 1'b0;
        if (start) begin
            running_d = (t_min_q != 6'd0) || (t_sec_q != 6'd0);
            buzz_d    = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= CLOCK;
            btn_q       <= '0;
            hr24_q      <= '0;
            min_q       <= '0;
            sec_q       <= '0;
            day_q       <= 5'd1;
            month_q     <= 4'd1;
            year_q      <= 12'd2000;
            alarm_hr_q  <= '0;
            alarm_min_q <= '0;
            alarm_en_q  <= 1'b0;
            t_min_q     <= '0;
            t_sec_q     <= '0;
            running_q   <= 1'b0;
            buzz_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            btn_q       <= btn_d;
            hr24_q      <= hr24_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            day_q       <= day_d;
            month_q     <= month_d;
            year_q      <= year_d;
            alarm_hr_q  <= alarm_hr_d;
            alarm_min_q <= alarm_min_d;
            alarm_en_q  <= alarm_en_d;
            t_min_q     <= t_min_d;
            t_sec_q     <= t_sec_d;
            running_q   <= running_d;
            buzz_q      <= buzz_d;
        end
    end

    // Display and buzzer outputs, purely combinational from registers and AM_mode
    always_comb begin
        h12            = (hr24_q == 5'd0 || hr24_q == 5'd12) ? 5'd12 : (hr24_q > 5'd12) ? hr24_q - 5'd12 : hr24_q;
        hr             = {1'b0, AM_mode ? h12 : hr24_q};
        AM_PM          = AM_mode && hr24_q >= 5'd12;
        sec            = sec_q;
        min            = min_q;
        day            = day_q;
        month          = month_q;
        year           = year_q;
        timer_buzzer   = buzz_q;
        alarm_buzzer   = alarm_en_q && hr24_q == alarm_hr_q && min_q == alarm_min_q;
        timer_min_left = t_min_q;
        timer_sec_left = t_sec_q;
    end
endmodule

// File: tb/tb_clock_with_mode_fsm.sv
// tb_clock_with_mode_fsm: directed self-checking bench for clock_with_mode_fsm
module tb_clock_with_mode_fsm;
    localparam int MODE = 4, HOUR = 3, MINUTE = 2, TIMER = 1, ALARM = 0;

    logic        clk = 1'b0, reset = 1'b1, AM_mode = 1'b1;
    logic [4:0]  b = '0;
    logic [5:0]  sec, min, hr, timer_min_left, timer_sec_left;
    logic        AM_PM, timer_buzzer, alarm_buzzer;
    logic [4:0]  day;
    logic [3:0]  month;
    logic [11:0] year;
    logic [4:0]  f_hr, f_day;
    logic [5:0]  f_min, f_sec;
    logic [3:0]  f_mo;
    logic [11:0] f_yr;
    int          checks = 0, errors = 0, n;

    clock_with_mode_fsm dut (
        .clk(clk), .reset(reset), .mode_btn(b[MODE]), .add_hour(b[HOUR]), .add_minute(b[MINUTE]),
        .set_timer_btn(b[TIMER]), .set_alarm_btn(b[ALARM]), .AM_mode(AM_mode),
        .sec(sec), .min(min), .hr(hr), .AM_PM(AM_PM), .day(day), .month(month), .year(year),
        .timer_buzzer(timer_buzzer), .alarm_buzzer(alarm_buzzer),
        .timer_min_left(timer_min_left), .timer_sec_left(timer_sec_left)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse(input int k);
        @(negedge clk);
        b[k] = 1'b1;
        @(negedge clk);
        b[k] = 1'b0;
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task date_case(input string tag, input int d, input int mo, input int y, input int ed, input int emo, input int ey);
        @(negedge clk);
        f_hr = 5'd23; f_min = 6'd59; f_sec = 6'd59;
        f_day = 5'(d); f_mo = 4'(mo); f_yr = 12'(y);
        force dut.hr24_q = f_hr;
        force dut.min_q = f_min;
        force dut.sec_q = f_sec;
        force dut.day_q = f_day;
        force dut.month_q = f_mo;
        force dut.year_q = f_yr;
        #1;
        chk({tag, "_hr"}, 32'(dut.hr24_d), 0);
        chk({tag, "_min"}, 32'(dut.min_d), 0);
        chk({tag, "_sec"}, 32'(dut.sec_d), 0);
        chk({tag, "_day"}, 32'(dut.day_d), 32'(ed));
        chk({tag, "_month"}, 32'(dut.month_d), 32'(emo));
        chk({tag, "_year"}, 32'(dut.year_d), 32'(ey));
        release dut.hr24_q;
        release dut.min_q;
        release dut.sec_q;
        release dut.day_q;
        release dut.month_q;
        release dut.year_q;
    endtask

    initial begin
        do_reset;
        chk("rst_hr12", 32'(hr), 12);
        chk("rst_ampm", 32'(AM_PM), 0);
        chk("rst_alarm", 32'(alarm_buzzer), 0);
        chk("rst_sec", 32'(sec), 0);
        chk("rst_day", 32'(day), 1);
        chk("rst_month", 32'(month), 1);
        chk("rst_year", 32'(year), 2000);
        chk("rst_state", 32'(dut.state_q), 0);
        chk("rst_tbuzz", 32'(timer_buzzer), 0);

        pulse(HOUR);
        chk("adj_hr", 32'(hr), 1);
        chk("adj_sec_hold", 32'(sec), 1);
        repeat (11) pulse(HOUR);
        chk("noon_hr", 32'(hr), 12);
        chk("noon_pm", 32'(AM_PM), 1);
        pulse(HOUR);
        chk("h13_hr12", 32'(hr), 1);
        chk("h13_pm12", 32'(AM_PM), 1);
        AM_mode = 1'b0;
        #1;
        chk("h13_hr24", 32'(hr), 13);
        chk("h13_pm24", 32'(AM_PM), 0);
        AM_mode = 1'b1;
        pulse(MINUTE);
        chk("adj_min", 32'(min), 1);
        chk("adj_min_sec", 32'(sec), 14);

        date_case("d2023", 28, 2, 2023, 1, 3, 2023);
        date_case("d2024", 28, 2, 2024, 29, 2, 2024);
        date_case("d2024e", 29, 2, 2024, 1, 3, 2024);
        date_case("d2100", 28, 2, 2100, 1, 3, 2100);
        date_case("d2000", 28, 2, 2000, 29, 2, 2000);
        date_case("dapr", 30, 4, 2023, 1, 5, 2023);
        date_case("dyear", 31, 12, 4095, 1, 1, 0);

        AM_mode = 1'b0;
        do_reset;
        pulse(MODE);
        pulse(MODE);
        chk("al_state2", 32'(dut.state_q), 2);
        pulse(HOUR);
        pulse(MINUTE);
        chk("al_time_untouched", 32'(hr), 0);
        pulse(ALARM);
        chk("al_state0", 32'(dut.state_q), 0);
        chk("al_off_early", 32'(alarm_buzzer), 0);
        n = 0;
        while (!alarm_buzzer && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("al_rise", 32'(alarm_buzzer), 1);
        chk("al_rise_hr", 32'(hr), 1);
        chk("al_rise_min", 32'(min), 1);
        chk("al_rise_sec", 32'(sec), 0);
        n = 0;
        while (alarm_buzzer && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("al_width", 32'(n), 60);
        chk("al_fall_min", 32'(min), 2);
        chk("al_fall_sec", 32'(sec), 0);

        do_reset;
        pulse(MODE);
        pulse(MODE);
        @(negedge clk);
        b[MINUTE] = 1'b1;
        repeat (5) @(negedge clk);
        b[MINUTE] = 1'b0;
        @(negedge clk);
        chk("held_amin", 32'(dut.alarm_min_q), 1);
        chk("held_ahr", 32'(dut.alarm_hr_q), 0);

        do_reset;
        pulse(MODE);
        chk("tm_state1", 32'(dut.state_q), 1);
        pulse(MINUTE);
        repeat (3) pulse(HOUR);
        chk("tm_set_min", 32'(timer_min_left), 1);
        chk("tm_set_sec", 32'(timer_sec_left), 3);
        pulse(TIMER);
        chk("tm_start_state", 32'(dut.state_q), 0);
        chk("tm_start_min", 32'(timer_min_left), 1);
        chk("tm_start_sec", 32'(timer_sec_left), 3);
        repeat (62) @(negedge clk);
        chk("tm_62_sec", 32'(timer_sec_left), 1);
        chk("tm_62_buzz", 32'(timer_buzzer), 0);
        @(negedge clk);
        chk("tm_63_min", 32'(timer_min_left), 0);
        chk("tm_63_sec", 32'(timer_sec_left), 0);
        chk("tm_63_buzz", 32'(timer_buzzer), 1);
        repeat (5) @(negedge clk);
        chk("tm_hold_buzz", 32'(timer_buzzer), 1);
        chk("tm_hold_sec", 32'(timer_sec_left), 0);
        pulse(MODE);
        chk("tm_mode_clr", 32'(timer_buzzer), 0);

        do_reset;
        pulse(MODE);
        pulse(TIMER);
        repeat (3) @(negedge clk);
        chk("tz_min", 32'(timer_min_left), 0);
        chk("tz_sec", 32'(timer_sec_left), 0);
        chk("tz_buzz", 32'(timer_buzzer), 0);

        do_reset;
        pulse(MODE);
        pulse(MINUTE);
        pulse(TIMER);
        repeat (10) @(negedge clk);
        chk("tr_mid_min", 32'(timer_min_left), 0);
        chk("tr_mid_sec", 32'(timer_sec_left), 50);
        do_reset;
        chk("tr_rst_min", 32'(timer_min_left), 0);
        chk("tr_rst_sec", 32'(timer_sec_left), 0);
        chk("tr_rst_buzz", 32'(timer_buzzer), 0);
        chk("tr_rst_state", 32'(dut.state_q), 0);
        repeat (70) @(negedge clk);
        chk("tr_stays_idle", 32'(timer_buzzer), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
